// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb scheduler: arena geometry, cell encoding,
// slot state/struct and the row-major cell index helper.
package bomb_pkg;

    localparam int unsigned GRID  = 10;
    localparam int unsigned CELLS = GRID * GRID;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_ARMED = 2'b01;
    localparam logic [1:0] CELL_FIRE  = 2'b10;

    typedef enum logic [1:0] {
        SLOT_FREE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_BURN  = 2'd2
    } slot_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef struct packed {
        slot_state_e state;
        owner_e      owner;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  cnt;
    } slot_t;

    localparam slot_t SLOT_RESET = '{
        state: SLOT_FREE,
        owner: OWNER_A,
        x:     4'd0,
        y:     4'd0,
        cnt:   4'd0
    };

    function automatic logic [6:0] idx(input logic [3:0] x, input logic [3:0] y);
        return 7'(x) * 7'(GRID) + 7'(y);
    endfunction

endpackage

// File: rtl/bomb_grid_render.sv
// Combinational renderer: slot table plus wall map to the 2-bit-per-cell bomb map.
// Fire covers the centre and in-range, non-wall orthogonal neighbours; fire beats armed.
module bomb_grid_render
    import bomb_pkg::*;
#(
    parameter int unsigned SLOTS = 4
) (
    input  slot_state_e      i_state [SLOTS],
    input  logic [3:0]       i_x     [SLOTS],
    input  logic [3:0]       i_y     [SLOTS],
    input  logic [CELLS-1:0] i_walls,
    output logic [CELLS-1:0] o_bit0,
    output logic [CELLS-1:0] o_bit1
);

    logic [CELLS-1:0] w_fire;
    logic [CELLS-1:0] w_armed;

    always_comb begin
        w_fire  = '0;
        w_armed = '0;
        for (int s = 0; s < int'(SLOTS); s++) begin
            if (i_state[s] == SLOT_ARMED) begin
                w_armed[idx(i_x[s], i_y[s])] = 1'b1;
            end else if (i_state[s] == SLOT_BURN) begin
                w_fire[idx(i_x[s], i_y[s])] = 1'b1;
                // Neighbours never wrap across an edge and are blocked by walls.
                if (i_x[s] != 4'd0 && !i_walls[idx(i_x[s] - 4'd1, i_y[s])]) begin
                    w_fire[idx(i_x[s] - 4'd1, i_y[s])] = 1'b1;
                end
                if (i_x[s] < 4'(GRID - 1) && !i_walls[idx(i_x[s] + 4'd1, i_y[s])]) begin
                    w_fire[idx(i_x[s] + 4'd1, i_y[s])] = 1'b1;
                end
                if (i_y[s] != 4'd0 && !i_walls[idx(i_x[s], i_y[s] - 4'd1)]) begin
                    w_fire[idx(i_x[s], i_y[s] - 4'd1)] = 1'b1;
                end
                if (i_y[s] < 4'(GRID - 1) && !i_walls[idx(i_x[s], i_y[s] + 4'd1)]) begin
                    w_fire[idx(i_x[s], i_y[s] + 4'd1)] = 1'b1;
                end
            end
        end
        o_bit1 = w_fire;
        o_bit0 = w_armed & ~w_fire;
    end

endmodule

// File: rtl/bomb_sched.sv
// Central bomb scheduler: round-robin arbitration of A/B placement requests into a shared
// slot table, fuse/blast timers on tick, registered map. Optional chaining: BOMB_CHAIN_EN.
module bomb_sched
    import bomb_pkg::*;
#(
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned MAX_PER = 2,
    parameter int unsigned FUSE    = 3,
    parameter int unsigned BLAST   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             bombA_v,
    input  logic             bombB_v,
    input  logic [3:0]       bombA_x,
    input  logic [3:0]       bombA_y,
    input  logic [3:0]       bombB_x,
    input  logic [3:0]       bombB_y,
    input  logic [CELLS-1:0] onedim_Arena,
    output logic [CELLS-1:0] Bomb_bit0,
    output logic [CELLS-1:0] Bomb_bit1,
    output logic             ackA,
    output logic             ackB,
    output logic             full
);

    slot_t            r_slots   [SLOTS];
    slot_t            w_slots_d [SLOTS];
    owner_e           r_rr_ptr;
    owner_e           w_rr_ptr_d;
    logic             r_ackA;
    logic             r_ackB;
    logic [CELLS-1:0] r_bit0;
    logic [CELLS-1:0] r_bit1;
    logic [CELLS-1:0] w_bit0;
    logic [CELLS-1:0] w_bit1;

    slot_state_e      w_state [SLOTS];
    logic [3:0]       w_sx    [SLOTS];
    logic [3:0]       w_sy    [SLOTS];

    int unsigned      w_live_a;
    int unsigned      w_live_b;
    logic             w_occ_a;
    logic             w_occ_b;
    logic             w_has_free;
    int               w_free_idx;
    logic             w_elig_a;
    logic             w_elig_b;
    logic             w_grant_a;
    logic             w_grant_b;
    owner_e           w_req_owner;
    logic [3:0]       w_req_x;
    logic [3:0]       w_req_y;

    // Eligibility is computed purely from registered state, so a slot freed at this edge
    // is not reusable until the next one.
    always_comb begin : slot_scan
        w_live_a   = 0;
        w_live_b   = 0;
        w_occ_a    = 1'b0;
        w_occ_b    = 1'b0;
        w_has_free = 1'b0;
        w_free_idx = 0;
        for (int s = int'(SLOTS) - 1; s >= 0; s--) begin
            if (r_slots[s].state == SLOT_FREE) begin
                w_has_free = 1'b1;
                w_free_idx = s;
            end else begin
                if (r_slots[s].owner == OWNER_A) begin
                    w_live_a = w_live_a + 1;
                end else begin
                    w_live_b = w_live_b + 1;
                end
                if (r_slots[s].x == bombA_x && r_slots[s].y == bombA_y) begin
                    w_occ_a = 1'b1;
                end
                if (r_slots[s].x == bombB_x && r_slots[s].y == bombB_y) begin
                    w_occ_b = 1'b1;
                end
            end
        end
    end

    assign w_elig_a = bombA_v && (bombA_x <= 4'(GRID - 1)) && (bombA_y <= 4'(GRID - 1)) &&
                      !w_occ_a && (w_live_a < MAX_PER) && w_has_free;
    assign w_elig_b = bombB_v && (bombB_x <= 4'(GRID - 1)) && (bombB_y <= 4'(GRID - 1)) &&
                      !w_occ_b && (w_live_b < MAX_PER) && w_has_free;

    always_comb begin : arbitrate
        w_grant_a  = w_elig_a && (!w_elig_b || r_rr_ptr == OWNER_A);
        w_grant_b  = w_elig_b && (!w_elig_a || r_rr_ptr == OWNER_B);
        w_rr_ptr_d = r_rr_ptr;
        if (w_elig_a && w_elig_b) begin
            w_rr_ptr_d = (r_rr_ptr == OWNER_A) ? OWNER_B : OWNER_A;
        end
        w_req_owner = w_grant_b ? OWNER_B : OWNER_A;
        w_req_x     = w_grant_b ? bombB_x : bombA_x;
        w_req_y     = w_grant_b ? bombB_y : bombA_y;
    end

    always_comb begin : slot_next
        for (int s = 0; s < int'(SLOTS); s++) begin
            w_slots_d[s] = r_slots[s];
            case (r_slots[s].state)
                SLOT_FREE: begin
                    if ((w_grant_a || w_grant_b) && s == w_free_idx) begin
                        w_slots_d[s].state = SLOT_ARMED;
                        w_slots_d[s].owner = w_req_owner;
                        w_slots_d[s].x     = w_req_x;
                        w_slots_d[s].y     = w_req_y;
                        w_slots_d[s].cnt   = 4'(FUSE);
                    end
                end
                SLOT_ARMED: begin
`ifdef BOMB_CHAIN_EN
                    if (w_bit1[idx(r_slots[s].x, r_slots[s].y)]) begin
                        w_slots_d[s].state = SLOT_BURN;
                        w_slots_d[s].cnt   = 4'(BLAST);
                    end else
`endif
                    if (tick) begin
                        if (r_slots[s].cnt == 4'd1) begin
                            w_slots_d[s].state = SLOT_BURN;
                            w_slots_d[s].cnt   = 4'(BLAST);
                        end else begin
                            w_slots_d[s].cnt = r_slots[s].cnt - 4'd1;
                        end
                    end
                end
                SLOT_BURN: begin
                    if (tick) begin
                        if (r_slots[s].cnt == 4'd1) begin
                            w_slots_d[s].state = SLOT_FREE;
                        end else begin
                            w_slots_d[s].cnt = r_slots[s].cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    w_slots_d[s].state = SLOT_FREE;
                end
            endcase
        end
    end

    always_comb begin : render_feed
        for (int s = 0; s < int'(SLOTS); s++) begin
            w_state[s] = r_slots[s].state;
            w_sx[s]    = r_slots[s].x;
            w_sy[s]    = r_slots[s].y;
        end
    end

    bomb_grid_render #(
        .SLOTS (SLOTS)
    ) u_render (
        .i_state (w_state),
        .i_x     (w_sx),
        .i_y     (w_sy),
        .i_walls (onedim_Arena),
        .o_bit0  (w_bit0),
        .o_bit1  (w_bit1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SLOTS); s++) begin
                r_slots[s] <= SLOT_RESET;
            end
            r_rr_ptr <= OWNER_A;
            r_ackA   <= 1'b0;
            r_ackB   <= 1'b0;
            r_bit0   <= '0;
            r_bit1   <= '0;
        end else begin
            for (int s = 0; s < int'(SLOTS); s++) begin
                r_slots[s] <= w_slots_d[s];
            end
            r_rr_ptr <= w_rr_ptr_d;
            r_ackA   <= w_grant_a;
            r_ackB   <= w_grant_b;
            r_bit0   <= w_bit0;
            r_bit1   <= w_bit1;
        end
    end

    assign Bomb_bit0 = r_bit0;
    assign Bomb_bit1 = r_bit1;
    assign ackA      = r_ackA;
    assign ackB      = r_ackB;
    assign full      = !w_has_free;

endmodule

// File: tb/tb_bomb_sched.sv
// Scoreboard bench for bomb_sched: a bomb-lifetime reference model predicts each cycle's
// outputs into a queue that a negedge monitor pops and compares.
module tb_bomb_sched;

    localparam int SLOTS   = 4;
    localparam int MAX_PER = 2;
    localparam int FUSE    = 3;
    localparam int BLAST   = 2;
`ifdef BOMB_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int owner;
        int t;      // ticks lived: armed while t<FUSE, burning while t<FUSE+BLAST
    } bomb_t;

    typedef struct {
        logic        ack_a;
        logic        ack_b;
        logic        full;
        logic [99:0] b0;
        logic [99:0] b1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        va = 1'b0;
    logic        vb = 1'b0;
    logic [3:0]  ax = '0;
    logic [3:0]  ay = '0;
    logic [3:0]  bx = '0;
    logic [3:0]  by = '0;
    logic [99:0] walls = '0;
    logic [99:0] Bomb_bit0;
    logic [99:0] Bomb_bit1;
    logic        ackA;
    logic        ackB;
    logic        full;

    bomb_t bombs[$];
    exp_t  exp_q[$];
    exp_t  mon_e;
    int    ptr = 0;
    int    dx[4] = '{-1, 1, 0, 0};
    int    dy[4] = '{0, 0, -1, 1};
    int    n_checks = 0;
    int    n_pass = 0;

    bomb_sched #(
        .SLOTS   (SLOTS),
        .MAX_PER (MAX_PER),
        .FUSE    (FUSE),
        .BLAST   (BLAST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .bombA_v      (va),
        .bombB_v      (vb),
        .bombA_x      (ax),
        .bombA_y      (ay),
        .bombB_x      (bx),
        .bombB_y      (by),
        .onedim_Arena (walls),
        .Bomb_bit0    (Bomb_bit0),
        .Bomb_bit1    (Bomb_bit1),
        .ackA         (ackA),
        .ackB         (ackB),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [99:0] act, input logic [99:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("ackA", ackA, mon_e.ack_a);
            check("ackB", ackB, mon_e.ack_b);
            check("full", full, mon_e.full);
            check("Bomb_bit0", Bomb_bit0, mon_e.b0);
            check("Bomb_bit1", Bomb_bit1, mon_e.b1);
        end
    end

    task automatic render(output logic [99:0] b0, output logic [99:0] b1);
        logic [99:0] fire;
        logic [99:0] armed;
        fire  = '0;
        armed = '0;
        foreach (bombs[i]) begin
            if (bombs[i].t < FUSE) begin
                armed[bombs[i].x * 10 + bombs[i].y] = 1'b1;
            end else begin
                fire[bombs[i].x * 10 + bombs[i].y] = 1'b1;
                for (int d = 0; d < 4; d++) begin
                    int nx;
                    int ny;
                    nx = bombs[i].x + dx[d];
                    ny = bombs[i].y + dy[d];
                    if (nx >= 0 && nx <= 9 && ny >= 0 && ny <= 9 && !walls[nx * 10 + ny])
                        fire[nx * 10 + ny] = 1'b1;
                end
            end
        end
        b1 = fire;
        b0 = armed & ~fire;
    endtask

    function automatic bit eligible(input bit v, input int own, input int x, input int y);
        int live = 0;
        if (!v || x > 9 || y > 9 || bombs.size() >= SLOTS) return 1'b0;
        foreach (bombs[i]) begin
            if (bombs[i].owner == own) live++;
            if (bombs[i].x == x && bombs[i].y == y) return 1'b0;
        end
        return live < MAX_PER;
    endfunction

    // Drive one cycle, advance the model across the edge, queue the expected outputs.
    task automatic step(input bit a_v, input int a_x, input int a_y,
                        input bit b_v, input int b_x, input int b_y, input bit tk);
        exp_t        e;
        bit          ea;
        bit          eb;
        bit          ga;
        bit          gb;
        logic [99:0] m0;
        logic [99:0] m1;
        va   = a_v;
        ax   = 4'(a_x);
        ay   = 4'(a_y);
        vb   = b_v;
        bx   = 4'(b_x);
        by   = 4'(b_y);
        tick = tk;
        render(m0, m1);
        ea = eligible(a_v, 0, a_x, a_y);
        eb = eligible(b_v, 1, b_x, b_y);
        ga = ea && (!eb || ptr == 0);
        gb = eb && (!ea || ptr == 1);
        if (ea && eb) ptr = 1 - ptr;
        for (int i = bombs.size() - 1; i >= 0; i--) begin
            bomb_t b;
            b = bombs[i];
            if (CHAIN && b.t < FUSE && m1[b.x * 10 + b.y]) b.t = FUSE;
            else if (tk) b.t++;
            if (b.t >= FUSE + BLAST) bombs.delete(i);
            else bombs[i] = b;
        end
        if (ga) bombs.push_back('{x: a_x, y: a_y, owner: 0, t: 0});
        if (gb) bombs.push_back('{x: b_x, y: b_y, owner: 1, t: 0});
        e.ack_a = ga;
        e.ack_b = gb;
        e.full  = (bombs.size() == SLOTS);
        e.b0    = m0;
        e.b1    = m1;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    function automatic int rnd_coord();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return int'($urandom_range(10, 15));
        if (r == 1) return 0;
        if (r == 2) return 9;
        return int'($urandom_range(0, 9));
    endfunction

    task automatic run_random(input int n);
        bit a_v = 1'b0;
        bit b_v = 1'b0;
        int a_x = 0;
        int a_y = 0;
        int b_x = 0;
        int b_y = 0;
        for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                a_v = ($urandom_range(0, 4) != 0);
                a_x = rnd_coord();
                a_y = rnd_coord();
            end
            if ($urandom_range(0, 3) == 0) begin
                b_v = ($urandom_range(0, 4) != 0);
                b_x = rnd_coord();
                b_y = rnd_coord();
            end
            step(a_v, a_x, a_y, b_v, b_x, b_y, $urandom_range(0, 2) == 0);
        end
    endtask

    // Asynchronous reset away from the clock edge; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        va  = 1'b1;
        vb  = 1'b1;
        #1;
        check("rst_bit0", Bomb_bit0, '0);
        check("rst_bit1", Bomb_bit1, '0);
        check("rst_ackA", ackA, 1'b0);
        check("rst_ackB", ackB, 1'b0);
        check("rst_full", full, 1'b0);
        bombs.delete();
        ptr = 0;
        for (int i = 0; i < 100; i++) walls[i] = ($urandom_range(0, 4) == 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();
        // Held request at (1,1): exactly one accept.
        repeat (5) step(1'b1, 1, 1, 1'b0, 0, 0, 1'b0);
        // Simultaneous A and B with pointer at A.
        repeat (3) step(1'b1, 2, 2, 1'b1, 8, 8, 1'b0);
        run_random(1500);
        do_reset();
        step(1'b1, 0, 0, 1'b1, 9, 9, 1'b0);
        run_random(1500);
        @(negedge clk);
        #1;
        check("queue_drained", 100'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
